// File: rtl/gl_raster_pkg.sv
// gl_raster_pkg: shared vertex/triangle types and issue-FSM states for gl_raster_sched.
package gl_raster_pkg;
  localparam int VTX_W = 96;
  typedef logic [VTX_W-1:0] vtx_t;
  typedef struct packed {
    vtx_t v1;
    vtx_t v2;
    vtx_t v3;
  } tri_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
endpackage

// File: rtl/gl_tri_fifo.sv
// gl_tri_fifo: synchronous triangle FIFO; full is registered and held high through reset so no push lands before release.
module gl_tri_fifo import gl_raster_pkg::*; #(
  parameter type T = tri_t,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  logic pop_i,
  input  T     din_i,
  output T     dout_o,
  output logic empty_o,
  output logic full_o
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q, cnt_d;
  logic full_q;
  always_comb begin
    cnt_d = cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    dout_o = mem[rd_q];
    empty_o = cnt_q == '0;
    full_o = full_q;
  end
  always_ff @(posedge clk)
    if (push_i) mem[wr_q] <= din_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      full_q <= 1'b1;
    end else begin
      wr_q <= wr_q + AW'(push_i);
      rd_q <= rd_q + AW'(pop_i);
      cnt_q <= cnt_d;
      full_q <= cnt_d == (AW+1)'(DEPTH);
    end
endmodule

// File: rtl/gl_raster_sched.sv
// gl_raster_sched: assembles vertices into triangles, buffers them and issues each to the rasterizer.
// GL_TRI_STRIP_EN adds the strip_mode input and triangle-strip assembly.
module gl_raster_sched #(
  parameter int VTX_W = gl_raster_pkg::VTX_W,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vtx_valid,
  input  logic [VTX_W-1:0] vtx_data,
  input  logic             vtx_last,
`ifdef GL_TRI_STRIP_EN
  input  logic             strip_mode,
`endif
  output logic             vtx_ready,
  output logic             rast_start,
  output logic [VTX_W-1:0] rast_v1,
  output logic [VTX_W-1:0] rast_v2,
  output logic [VTX_W-1:0] rast_v3,
  input  logic             rast_done,
  output logic             busy,
  output logic [CNT_W-1:0] tri_count,
  output logic [CNT_W-1:0] drop_count
);
  import gl_raster_pkg::*;
  typedef struct packed {
    logic [VTX_W-1:0] v1;
    logic [VTX_W-1:0] v2;
    logic [VTX_W-1:0] v3;
  } trio_t;
  logic acc, push, pop, drop, empty, full, strip, odd, done_edge;
  logic [1:0] slot_q, slot_d;
  logic [VTX_W-1:0] s0_q, s1_q;
  trio_t din, head, v_q;
  state_e state_q, state_d;
  logic done_q;
  logic [CNT_W-1:0] tri_q, drop_q;
  gl_tri_fifo #(.T(trio_t), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(push), .pop_i(pop), .din_i(din),
    .dout_o(head), .empty_o(empty), .full_o(full)
  );
`ifdef GL_TRI_STRIP_EN
  logic strip_q, fresh_q, odd_q;
  // The mode is latched on the first vertex of a batch; odd_q tracks winding parity within a strip.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      strip_q <= 1'b0;
      fresh_q <= 1'b1;
      odd_q <= 1'b0;
    end else if (acc) begin
      fresh_q <= vtx_last;
      strip_q <= fresh_q ? strip_mode : strip_q;
      odd_q <= vtx_last ? 1'b0 : odd_q ^ (push & strip_q);
    end
  assign strip = strip_q;
  assign odd = odd_q;
`else
  assign strip = 1'b0;
  assign odd = 1'b0;
`endif
  always_comb begin
    vtx_ready = !full;
    acc = vtx_valid & vtx_ready;
    push = acc & (slot_q == 2'd2);
    drop = acc & vtx_last & (slot_q != 2'd2);
    slot_d = !acc ? slot_q : vtx_last ? 2'd0 : (slot_q != 2'd2) ? slot_q + 2'd1 : strip ? 2'd2 : 2'd0;
    din = odd ? {s1_q, s0_q, vtx_data} : {s0_q, s1_q, vtx_data};
    pop = (state_q == IDLE) & !empty;
    done_edge = rast_done & !done_q;
    state_d = (state_q == IDLE) ? (empty ? IDLE : ISSUE) : (state_q == ISSUE) ? WAIT : (done_edge ? IDLE : WAIT);
    rast_start = state_q == ISSUE;
    busy = !empty | (state_q != IDLE);
    rast_v1 = v_q.v1;
    rast_v2 = v_q.v2;
    rast_v3 = v_q.v3;
    tri_count = tri_q;
    drop_count = drop_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      slot_q <= '0;
      s0_q <= '0;
      s1_q <= '0;
      state_q <= IDLE;
      done_q <= 1'b0;
      v_q <= '0;
      tri_q <= '0;
      drop_q <= '0;
    end else begin
      slot_q <= slot_d;
      s0_q <= (acc && slot_q == 2'd0) ? vtx_data : (push && strip) ? s1_q : s0_q;
      s1_q <= (acc && slot_q == 2'd1) || (push && strip) ? vtx_data : s1_q;
      state_q <= state_d;
      done_q <= rast_done;
      v_q <= pop ? head : v_q;
      tri_q <= (state_q == WAIT && done_edge) ? tri_q + CNT_W'(1) : tri_q;
      drop_q <= (drop && !(&drop_q)) ? drop_q + CNT_W'(1) : drop_q;
    end
endmodule

// File: tb/tb_gl_raster_sched.sv
// tb_gl_raster_sched: directed scenarios for gl_raster_sched with hand-computed expectations.
module tb_gl_raster_sched;
  logic clk = 1'b0, rst_n = 1'b0, vtx_valid = 1'b0, vtx_last = 1'b0, rast_done = 1'b0;
  logic [95:0] vtx_data = '0;
  logic vtx_ready, rast_start, busy;
  logic [95:0] rast_v1, rast_v2, rast_v3;
  logic [15:0] tri_count, drop_count;
  int pass_cnt = 0, total_cnt = 0;
`ifdef GL_TRI_STRIP_EN
  logic strip_mode = 1'b0;
`endif
  gl_raster_sched dut (
    .clk(clk), .rst_n(rst_n), .vtx_valid(vtx_valid), .vtx_data(vtx_data), .vtx_last(vtx_last),
`ifdef GL_TRI_STRIP_EN
    .strip_mode(strip_mode),
`endif
    .vtx_ready(vtx_ready), .rast_start(rast_start), .rast_v1(rast_v1), .rast_v2(rast_v2), .rast_v3(rast_v3),
    .rast_done(rast_done), .busy(busy), .tri_count(tri_count), .drop_count(drop_count)
  );
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [95:0] d, input logic last);
    int n = 0;
    vtx_valid = 1'b1;
    vtx_data = d;
    vtx_last = last;
    while (!vtx_ready && n < 40) begin tick(); n++; end
    if (n >= 40) begin total_cnt++; $display("FAIL send_timeout: vtx_ready=%b required 1 within 40 cycles", vtx_ready); end
    tick();
    vtx_valid = 1'b0;
    vtx_last = 1'b0;
  endtask
  task automatic wait_start();
    int n = 0;
    while (!rast_start && n < 20) begin tick(); n++; end
    if (n >= 20) begin total_cnt++; $display("FAIL start_timeout: rast_start=%b required 1 within 20 cycles", rast_start); end
  endtask
  task automatic finish_tri();
    tick();
    rast_done = 1'b1;
    tick();
    rast_done = 1'b0;
  endtask
  task automatic test_reset();
    #12;
    total_cnt++; if (vtx_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", vtx_ready); else pass_cnt++;
    total_cnt++; if (rast_start !== 1'b0) $display("FAIL reset_start: got %b want 0", rast_start); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (tri_count !== 16'd0 || drop_count !== 16'd0) $display("FAIL reset_counts: got %0d/%0d want 0/0", tri_count, drop_count); else pass_cnt++;
    total_cnt++; if (rast_v1 !== 96'd0) $display("FAIL reset_v1: got %h want 0", rast_v1); else pass_cnt++;
    tick();
    rst_n = 1'b1;
    total_cnt++; if (vtx_ready !== 1'b0) $display("FAIL release_ready_early: got %b want 0", vtx_ready); else pass_cnt++;
    tick();
    total_cnt++; if (vtx_ready !== 1'b1) $display("FAIL release_ready: got %b want 1", vtx_ready); else pass_cnt++;
  endtask
  task automatic test_single();
    send({32'h3F80_0000, 64'd0}, 1'b0);
    send({32'h4000_0000, 64'd0}, 1'b0);
    send({32'h4040_0000, 64'd0}, 1'b0);
    total_cnt++; if (rast_start !== 1'b0) $display("FAIL single_start_early: got %b want 0", rast_start); else pass_cnt++;
    tick();
    total_cnt++; if (rast_start !== 1'b1) $display("FAIL single_start: got %b want 1", rast_start); else pass_cnt++;
    total_cnt++; if (rast_v1 !== {32'h3F80_0000, 64'd0}) $display("FAIL single_v1: got %h want 3f800000..", rast_v1); else pass_cnt++;
    total_cnt++; if (rast_v2 !== {32'h4000_0000, 64'd0}) $display("FAIL single_v2: got %h want 40000000..", rast_v2); else pass_cnt++;
    total_cnt++; if (rast_v3 !== {32'h4040_0000, 64'd0}) $display("FAIL single_v3: got %h want 40400000..", rast_v3); else pass_cnt++;
    tick();
    total_cnt++; if (rast_start !== 1'b0 || busy !== 1'b1) $display("FAIL single_pulse: start=%b busy=%b want 0/1", rast_start, busy); else pass_cnt++;
    rast_done = 1'b1;
    tick();
    rast_done = 1'b0;
    total_cnt++; if (tri_count !== 16'd1) $display("FAIL single_tri_count: got %0d want 1", tri_count); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL single_busy_end: got %b want 0", busy); else pass_cnt++;
  endtask
  task automatic test_fill();
    for (int t = 0; t < 5; t++)
      for (int j = 1; j <= 3; j++) send(96'(100 + 3 * t + j), 1'b0);
    total_cnt++; if (vtx_ready !== 1'b0) $display("FAIL fill_ready_low: got %b want 0", vtx_ready); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1 || tri_count !== 16'd1) $display("FAIL fill_state: busy=%b tri=%0d want 1/1", busy, tri_count); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) wait_start();
      if (i == 1) begin
        total_cnt++; if (vtx_ready !== 1'b1) $display("FAIL fill_ready_back: got %b want 1", vtx_ready); else pass_cnt++;
      end
      total_cnt++; if (rast_v1 !== 96'(100 + 3 * i + 1) || rast_v3 !== 96'(100 + 3 * i + 3)) $display("FAIL fill_tri%0d: v1=%0d v3=%0d want %0d/%0d", i, rast_v1, rast_v3, 101 + 3 * i, 103 + 3 * i); else pass_cnt++;
      finish_tri();
      total_cnt++; if (tri_count !== 16'(2 + i)) $display("FAIL fill_count%0d: got %0d want %0d", i, tri_count, 2 + i); else pass_cnt++;
    end
    total_cnt++; if (busy !== 1'b0) $display("FAIL fill_busy_end: got %b want 0", busy); else pass_cnt++;
  endtask
  task automatic test_held_done();
    for (int j = 0; j < 3; j++) send(96'(200 + j), 1'b0);
    wait_start();
    tick();
    for (int j = 3; j < 6; j++) send(96'(200 + j), 1'b0);
    rast_done = 1'b1;
    repeat (8) tick();
    total_cnt++; if (tri_count !== 16'd7) $display("FAIL held_first: got %0d want 7", tri_count); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1 || rast_v1 !== 96'd203) $display("FAIL held_second_waiting: busy=%b v1=%0d want 1/203", busy, rast_v1); else pass_cnt++;
    rast_done = 1'b0;
    tick();
    rast_done = 1'b1;
    tick();
    rast_done = 1'b0;
    total_cnt++; if (tri_count !== 16'd8 || busy !== 1'b0) $display("FAIL held_second: tri=%0d busy=%b want 8/0", tri_count, busy); else pass_cnt++;
  endtask
  task automatic test_drop();
    logic saw = 1'b0;
    send(96'd300, 1'b0);
    send(96'd301, 1'b1);
    total_cnt++; if (drop_count !== 16'd1) $display("FAIL drop_count: got %0d want 1", drop_count); else pass_cnt++;
    repeat (5) begin tick(); saw = saw | rast_start; end
    total_cnt++; if (saw !== 1'b0 || busy !== 1'b0) $display("FAIL drop_no_start: start_seen=%b busy=%b want 0/0", saw, busy); else pass_cnt++;
    send(96'd302, 1'b0);
    send(96'd303, 1'b0);
    send(96'd304, 1'b0);
    wait_start();
    total_cnt++; if (rast_v1 !== 96'd302 || rast_v2 !== 96'd303 || rast_v3 !== 96'd304) $display("FAIL drop_clean_tri: got %0d,%0d,%0d want 302,303,304", rast_v1, rast_v2, rast_v3); else pass_cnt++;
    finish_tri();
    total_cnt++; if (tri_count !== 16'd9 || drop_count !== 16'd1) $display("FAIL drop_end_counts: tri=%0d drop=%0d want 9/1", tri_count, drop_count); else pass_cnt++;
  endtask
  task automatic test_reset_mid();
    for (int j = 0; j < 3; j++) send(96'(400 + j), 1'b0);
    wait_start();
    tick();
    for (int j = 3; j < 6; j++) send(96'(400 + j), 1'b0);
    rst_n = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0 || rast_start !== 1'b0 || vtx_ready !== 1'b0) $display("FAIL mid_reset_flags: busy=%b start=%b ready=%b want 0/0/0", busy, rast_start, vtx_ready); else pass_cnt++;
    total_cnt++; if (tri_count !== 16'd0 || drop_count !== 16'd0 || rast_v1 !== 96'd0) $display("FAIL mid_reset_regs: tri=%0d drop=%0d v1=%0d want 0/0/0", tri_count, drop_count, rast_v1); else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
    total_cnt++; if (vtx_ready !== 1'b1 || busy !== 1'b0) $display("FAIL mid_release: ready=%b busy=%b want 1/0", vtx_ready, busy); else pass_cnt++;
    send(96'd410, 1'b0);
    send(96'd411, 1'b0);
    send(96'd412, 1'b1);
    wait_start();
    total_cnt++; if (rast_v1 !== 96'd410 || rast_v3 !== 96'd412) $display("FAIL mid_new_tri: v1=%0d v3=%0d want 410/412", rast_v1, rast_v3); else pass_cnt++;
    finish_tri();
    total_cnt++; if (tri_count !== 16'd1 || busy !== 1'b0 || drop_count !== 16'd0) $display("FAIL mid_end: tri=%0d busy=%b drop=%0d want 1/0/0", tri_count, busy, drop_count); else pass_cnt++;
  endtask
`ifdef GL_TRI_STRIP_EN
  task automatic test_strip();
    int e1[3] = '{500, 502, 502};
    int e2[3] = '{501, 501, 503};
    int e3[3] = '{502, 503, 504};
    strip_mode = 1'b1;
    for (int j = 0; j < 5; j++) send(96'(500 + j), j == 4);
    strip_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) wait_start();
      total_cnt++; if (rast_v1 !== 96'(e1[i]) || rast_v2 !== 96'(e2[i]) || rast_v3 !== 96'(e3[i])) $display("FAIL strip_tri%0d: got %0d,%0d,%0d want %0d,%0d,%0d", i, rast_v1, rast_v2, rast_v3, e1[i], e2[i], e3[i]); else pass_cnt++;
      finish_tri();
    end
    total_cnt++; if (tri_count !== 16'd4 || drop_count !== 16'd0 || busy !== 1'b0) $display("FAIL strip_end: tri=%0d drop=%0d busy=%b want 4/0/0", tri_count, drop_count, busy); else pass_cnt++;
  endtask
`endif
  initial begin
    test_reset();
    test_single();
    test_fill();
    test_held_done();
    test_drop();
    test_reset_mid();
`ifdef GL_TRI_STRIP_EN
    test_strip();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/gl_raster_sched.md
Name: gl_raster_sched

Overview:
- Front-end controller for the gl_rasterizer triangle engine.
- Accepts a stream of 96-bit vertices with valid/ready and assembles them into triangles.
- Buffers assembled triangles in a small FIFO and issues them one at a time to the rasterizer: start pulse, hold the vertex triple, wait for the done edge.
- Keeps triangle and dropped-primitive statistics.

Parameters:
- VTX_W, 96, vertex word width ({x,y,z} fp32, x at [95:64], y at [63:32]).
- DEPTH, 4, triangle FIFO depth; power of two, at least 2.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock; all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- vtx_valid  in  1  vertex present on vtx_data.
- vtx_data  in  VTX_W  vertex word.
- vtx_last  in  1  marks the final vertex of a primitive batch; qualified by vtx_valid.
- vtx_ready  out  1  block can accept a vertex.
- rast_start  out  1  one-cycle start pulse to the rasterizer; drives its fifo_ready.
- rast_v1, rast_v2, rast_v3  out  VTX_W each  triangle vertices to the rasterizer fifo_in1/2/3.
- rast_done  in  1  rasterizer raster_ready; level signal, may stay high.
- busy  out  1  high when the FIFO is non-empty or the FSM is not in IDLE.
- tri_count  out  CNT_W  triangles completed; wraps.
- drop_count  out  CNT_W  partial triangles discarded; saturates at all-ones.

Behaviour:
- Reset state: all outputs 0, except vtx_ready which is 1 one cycle after reset release. FIFO empty, assembly slot 0, FSM in IDLE, rast_done edge register 0.
- Reset mid-operation: the in-flight triangle is abandoned. The rasterizer is reset by its owner, not by this block.
- Vertex accept:
  - vtx_ready = !fifo_full, registered from FIFO occupancy.
  - Accept = vtx_valid & vtx_ready.
  - A 2-bit slot counter stores accepted vertices in slots 0, 1, 2.
- Triangle push:
  - Accepting into slot 2 pushes {s0, s1, vtx_data} into the FIFO in the same cycle and returns the slot counter to 0.
  - The pushed triangle is visible at the FIFO head on the next cycle.
- vtx_last on an accept:
  - At slot 2: normal push.
  - At slot 0 or 1: the partial triangle is discarded, the slot counter returns to 0, and drop_count increments (saturating).
- FIFO occupancy:
  - A push and a pop in the same cycle leave occupancy unchanged.
  - When full, vtx_ready is low, so no push can occur.
  - A pop on a full FIFO raises vtx_ready on the next cycle.
- Issue FSM:
  - IDLE: if the FIFO is non-empty, latch the head into rast_v1..3, pop, go to ISSUE.
  - ISSUE: rast_start=1 for exactly this cycle; go to WAIT.
  - WAIT: on a rast_done rising edge (rast_done & !rast_done_q), tri_count++ and go to IDLE. Otherwise stay.
- rast_done edge handling:
  - rast_done_q is updated every cycle.
  - Edges seen while in IDLE or ISSUE are ignored.
  - A level that stays high never retriggers.
- Hold: rast_v1..3 are stable from the IDLE→ISSUE transition until the next IDLE pop.
- Latency: a slot-2 accept in cycle N with the FSM idle gives the pop at N+1 and rast_start high in N+2.
- Throughput: at most one triangle per 3 cycles plus the rasterizer time.
- Counters: tri_count wraps modulo 2^CNT_W.

Optional Feature:
- Macro: GL_TRI_STRIP_EN.
- Defined: adds input strip_mode (1 bit, sampled only at slot 0 after reset or after a vtx_last).
- strip_mode=1, after the first three vertices each new vertex emits a triangle from the last two plus the new one:
  - Odd triangles: (v[n-1], v[n-2], v[n]), which preserves winding for the edge-function signs.
  - Even triangles: (v[n-2], v[n-1], v[n]).
- In strip mode, vtx_last resets the strip. Two or fewer vertices in a strip count as one drop.
- Undefined: no strip_mode port; triangle-list behaviour only.

Decomposition:
- Package gl_raster_pkg: VTX_W, vertex typedef, triangle struct {v1, v2, v3}, FSM state enum {IDLE, ISSUE, WAIT}.
- Sub-module gl_tri_fifo: synchronous FIFO of triangle structs, parameterised by DEPTH, with full/empty/push/pop.

Test Plan:
- After reset, 3 vertices (x=1.0, 2.0, 3.0) → rast_start is one pulse 2 cycles after the 3rd accept, rast_v1..3 carry them in order. rast_done pulse → tri_count=1, busy=0.
- 5 triangles with rast_done held low → vtx_ready drops after the 4th triangle is buffered (DEPTH=4), with 1 triangle issued and waiting. Each done edge drains one; tri_count=5 at the end.
- rast_done held high across two triangles → the second completes only after rast_done goes low then high.
- 2 vertices with vtx_last on the 2nd → drop_count=1 and no rast_start. The next 3 vertices form a clean triangle.
- rst_n asserted mid-WAIT → outputs clear immediately, FIFO empty. New triangles after release issue normally.
- GL_TRI_STRIP_EN, strip_mode=1, vertices A B C D E → triangles (A,B,C), (C,B,D), (C,D,E).
